// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU and its program loader.
//   AW    - instruction address width (CPU pc width)
//   DW    - instruction word width
//   DEPTH - number of instruction words (2**AW)
//   state_e - loader FSM state encoding, also exported for debug
package cpu_pkg;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/prog_mem.sv
// DEPTH x DW instruction store built from flops.
// Ports:
//   clk   - clock, all writes on rising edge
//   clr   - synchronous clear of every word (wins over we)
//   we    - synchronous write enable
//   waddr - write address
//   wdata - write data
//   raddr - asynchronous read address
//   rdata - word at raddr (combinational)
module prog_mem
  import cpu_pkg::*;
#(
  parameter int P_AW    = AW,
  parameter int P_DW    = DW,
  parameter int P_DEPTH = DEPTH
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            we,
  input  logic [P_AW-1:0] waddr,
  input  logic [P_DW-1:0] wdata,
  input  logic [P_AW-1:0] raddr,
  output logic [P_DW-1:0] rdata
);

  logic [P_DW-1:0] mem_q [P_DEPTH];
  logic [P_DW-1:0] mem_d [P_DEPTH];

  always_comb begin
    for (int i = 0; i < P_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (clr) begin
      for (int i = 0; i < P_DEPTH; i++) begin
        mem_d[i] = '0;
      end
    end else if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < P_DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_loader.sv
// Program loader and instruction memory for the 4-bit CPU.
// A host streams instruction bytes in while the CPU is held in reset; once
// the program is complete the CPU is released and its fetches are served
// from the store until it halts.
//
// Handshake: a byte transfers on a rising edge where in_valid and in_ready
// are both 1. in_ready depends only on registered state, never on in_valid;
// while in_ready is 0 the byte is left untouched and not consumed.
//
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   load_req          - one-cycle pulse: clear memory and (re)start a load
//   in_valid/in_data/in_last/in_ready - instruction byte stream
//   pc / instr        - CPU fetch address and combinational instruction
//   halt              - CPU halt indication (only honoured in RUN)
//   cpu_reset         - active-high reset to the CPU core
//   load_count        - bytes written by the most recent load
//   done              - CPU has halted since last release
//   dbg_state         - current FSM state, for observation
module prog_loader
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load_req,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  input  logic [AW-1:0] pc,
  output logic [DW-1:0] instr,
  input  logic          halt,
  output logic          cpu_reset,
  output logic [AW:0]   load_count,
  output logic          done,
  output state_e        dbg_state
);

  localparam logic [AW:0] LAST_SLOT = (AW+1)'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          mem_clr, mem_we;
  logic          accept;

  // Outputs are pure decodes of registered state.
  assign in_ready  = (state_q == ST_LOAD);
  assign cpu_reset = (state_q != ST_RUN);
  assign done      = (state_q == ST_HALTED);
  assign dbg_state = state_q;
  assign load_count = count_q;

  assign accept = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_clr  = 1'b0;
    mem_we   = 1'b0;

    if (load_req) begin
      // load_req beats halt and any same-cycle accept in every state.
      state_d  = ST_LOAD;
      wr_ptr_d = '0;
      count_d  = '0;
      mem_clr  = 1'b1;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
            // Terminate on in_last or when the store is full.
            if (in_last || (count_q == LAST_SLOT)) begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (halt) begin
            state_d = ST_HALTED;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  prog_mem #(
    .P_AW    (AW),
    .P_DW    (DW),
    .P_DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .clr   (mem_clr | reset),
    .we    (mem_we & ~reset),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (pc),
    .rdata (instr)
  );

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: bytes expected in memory are queued as
// they are driven and popped when the store is read back through pc/instr.
module tb_prog_loader;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          load_req = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [AW-1:0] pc = '0;
  logic [DW-1:0] instr;
  logic          halt = 1'b0;
  logic          cpu_reset;
  logic [AW:0]   load_count;
  logic          done;
  state_e        dbg_state;

  prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .load_req   (load_req),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .pc         (pc),
    .instr      (instr),
    .halt       (halt),
    .cpu_reset  (cpu_reset),
    .load_count (load_count),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge; all driving and sampling
  // happens here, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  task automatic pulse_load();
    exp_q.delete();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  // acc: whether the design should take this byte into memory
  task automatic send(input logic [DW-1:0] d, input logic last, input bit acc);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    if (acc) exp_q.push_back(d);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Read every address; unqueued addresses must hold 0.
  task automatic verify_mem(input string tag);
    logic [DW-1:0] e;
    for (int a = 0; a < DEPTH; a++) begin
      pc = AW'(a);
      #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      check($sformatf("%s_mem%0d", tag, a), 32'(instr), 32'(e));
    end
    pc = '0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset then idle
    do_reset(2);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_load_count", 32'(load_count), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    verify_mem("rst");

    // Normal load of three bytes
    pulse_load();
    check("ld_in_ready", 32'(in_ready), 32'd1);
    check("ld_cpu_reset", 32'(cpu_reset), 32'd1);
    send(8'h12, 1'b0, 1'b1);
    pc = '0;
    #1;
    check("ld_first_byte_latency", 32'(instr), 32'h12);
    send(8'h34, 1'b0, 1'b1);
    check("ld_cpu_reset_before_last", 32'(cpu_reset), 32'd1);
    send(8'h56, 1'b1, 1'b1);
    check("ld_cpu_reset_released", 32'(cpu_reset), 32'd0);
    check("ld_state_run", 32'(dbg_state), 32'(ST_RUN));
    check("ld_count3", 32'(load_count), 32'd3);
    verify_mem("ld");

    // Gaps in the stream
    pulse_load();
    send(8'hA1, 1'b0, 1'b1);
    in_valid = 1'b0;
    in_data  = 8'hEE;
    in_last  = 1'b1;
    step();
    in_last  = 1'b0;
    check("gap_still_loading", 32'(in_ready), 32'd1);
    send(8'hA2, 1'b1, 1'b1);
    check("gap_count2", 32'(load_count), 32'd2);
    verify_mem("gap");

    // Bytes offered in RUN are not consumed
    send(8'h77, 1'b1, 1'b0);
    check("run_ignore_count", 32'(load_count), 32'd2);
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    verify_mem("run_ignore");

    // Overflow: 20 bytes, none marked last
    pulse_load();
    for (int i = 0; i < 20; i++) begin
      send(DW'(i), 1'b0, i < DEPTH);
      if (i == DEPTH - 2) check("ovf_not_yet_run", 32'(dbg_state), 32'(ST_LOAD));
      if (i == DEPTH - 1) check("ovf_run_after_16", 32'(dbg_state), 32'(ST_RUN));
    end
    check("ovf_count16", 32'(load_count), 32'd16);
    check("ovf_in_ready", 32'(in_ready), 32'd0);
    check("ovf_cpu_reset", 32'(cpu_reset), 32'd0);
    verify_mem("ovf");

    // Halt and reload
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt_state", 32'(dbg_state), 32'(ST_HALTED));
    check("halt_done", 32'(done), 32'd1);
    check("halt_cpu_reset", 32'(cpu_reset), 32'd1);
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt_in_halted_ignored", 32'(dbg_state), 32'(ST_HALTED));
    pulse_load();
    check("reload_done_cleared", 32'(done), 32'd0);
    send(8'hFF, 1'b1, 1'b1);
    check("reload_count1", 32'(load_count), 32'd1);
    check("reload_run", 32'(cpu_reset), 32'd0);
    verify_mem("reload");

    // load_req beats a same-cycle halt in RUN
    halt = 1'b1;
    pulse_load();
    halt = 1'b0;
    check("abort_cpu_reset", 32'(cpu_reset), 32'd1);
    check("abort_state", 32'(dbg_state), 32'(ST_LOAD));
    check("abort_count0", 32'(load_count), 32'd0);
    verify_mem("abort");

    // load_req beats a same-cycle accept
    send(8'h55, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h66;
    pulse_load();
    in_valid = 1'b0;
    check("prio_count0", 32'(load_count), 32'd0);
    check("prio_in_ready", 32'(in_ready), 32'd1);
    verify_mem("prio");

    // Sync reset after 2 of 5 bytes
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    check("mid_count2", 32'(load_count), 32'd2);
    do_reset(1);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("mid_rst_count", 32'(load_count), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    verify_mem("mid_rst");

    // halt in IDLE is ignored
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("idle_halt_ignored", 32'(dbg_state), 32'(ST_IDLE));
    check("idle_done", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
